// File: rtl/adff_arb_pkg.sv
// Shared types and constants for the round-robin arbiter
// in front of the adff shared register.
package adff_arb_pkg;

  typedef enum logic {IDLE, OWNED} state_t;

  localparam int N_REQ_DEF    = 4;
  localparam int WIDTH_DEF    = 2;
  localparam int MAX_HOLD_DEF = 3;

  // Bits needed to index n items, never less than one.
  function automatic int ow(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adff_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request
// scanning from start upward, wrapping modulo N.
module rr_pick
  import adff_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int OW = ow(N_REQ_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] start,
  output logic          valid,
  output logic [OW-1:0] win
);

  localparam logic [OW:0] NV = (OW+1)'(N);

  logic [N-1:0]  rot;
  logic [OW-1:0] off;
  logic [OW:0]   sum;

  // Rotate so that start lands on bit 0.
  assign rot = N'({req, req} >> start);

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = OW'(i);
    end
  end

  assign sum   = {1'b0, start} + {1'b0, off};
  assign win   = (sum >= NV) ? OW'(sum - NV) : sum[OW-1:0];
  assign valid = |req;

endmodule

// File: rtl/adff_rr_arbiter.sv
// Round-robin owner of a shared async-reset register with
// bounded LOCK bursts and same-edge rearbitration.
module adff_rr_arbiter
  import adff_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                     CLK,
  input  logic                     ARST,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ-1:0]         LOCK,
  input  logic [N_REQ*WIDTH-1:0]   DIN,
  output logic [N_REQ-1:0]         GNT,
  output logic [N_REQ-1:0]         ACK,
  output logic [WIDTH-1:0]         Q,
  output logic [ow(N_REQ)-1:0]     OWNER,
  output logic                     BUSY
);

  localparam int OW = ow(N_REQ);
  localparam int HW = ow(MAX_HOLD);
  localparam logic [OW-1:0] LAST      = OW'(N_REQ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [OW-1:0]    ptr, ptr_n;
  logic [OW-1:0]    owner_n, owner_inc;
  logic [OW-1:0]    start, win;
  logic [HW-1:0]    hold, hold_n;
  logic [N_REQ-1:0] gnt_n, ack_n, win_oh;
  logic [WIDTH-1:0] q_n;
  logic             valid, cont;

  assign owner_inc = (OWNER == LAST) ? '0 : OWNER + 1'b1;

  // Burst continues only for a locked, requesting owner below the cap.
  assign cont = (state == OWNED) && REQ[OWNER] &&
                LOCK[OWNER] && (hold < HOLD_LAST);

  // On release the scan starts past the owner, so it is tried last.
  assign start  = (state == OWNED) ? owner_inc : ptr;
  assign win_oh = N_REQ'(1) << win;

  rr_pick #(
    .N  (N_REQ),
    .OW (OW)
  ) u_pick (
    .req   (REQ),
    .start (start),
    .valid (valid),
    .win   (win)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = OWNER;
    hold_n  = hold;
    gnt_n   = GNT;
    ack_n   = '0;
    q_n     = Q;
    if (cont) begin
      q_n    = DIN[OWNER*WIDTH +: WIDTH];
      ack_n  = GNT;
      hold_n = hold + 1'b1;
    end else begin
      if (state == OWNED) ptr_n = owner_inc;
      if (valid) begin
        state_n = OWNED;
        gnt_n   = win_oh;
        ack_n   = win_oh;
        q_n     = DIN[win*WIDTH +: WIDTH];
        owner_n = win;
        hold_n  = '0;
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state <= IDLE;
      ptr   <= '0;
      OWNER <= '0;
      hold  <= '0;
      GNT   <= '0;
      ACK   <= '0;
      Q     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      OWNER <= owner_n;
      hold  <= hold_n;
      GNT   <= gnt_n;
      ACK   <= ack_n;
      Q     <= q_n;
    end
  end

  assign BUSY = (state == OWNED);

endmodule

// File: tb/tb_adff_rr_arbiter.sv
// Directed and randomized checks of adff_rr_arbiter against
// an integer-level model of the ownership rules.
module tb_adff_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int MH = 3;

  logic           CLK = 0;
  logic           ARST = 1;
  logic [N-1:0]   REQ = '0;
  logic [N-1:0]   LOCK = '0;
  logic [N*W-1:0] DIN = '0;
  logic [N-1:0]   GNT, ACK;
  logic [W-1:0]   Q;
  logic [1:0]     OWNER;
  logic           BUSY;

  int checks = 0;
  int passes = 0;

  int       m_ptr, m_owner, m_hold;
  bit       m_busy;
  logic [N-1:0] m_gnt, m_ack;
  logic [W-1:0] m_q;

  adff_rr_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .MAX_HOLD (MH)
  ) dut (
    .CLK   (CLK),
    .ARST  (ARST),
    .REQ   (REQ),
    .LOCK  (LOCK),
    .DIN   (DIN),
    .GNT   (GNT),
    .ACK   (ACK),
    .Q     (Q),
    .OWNER (OWNER),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int arb(input int start);
    for (int k = 0; k < N; k++) begin
      int i = (start + k) % N;
      if (REQ[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] din_of(input int i);
    return DIN[i*W +: W];
  endfunction

  task automatic m_grant(input int w);
    m_busy  = 1;
    m_owner = w;
    m_hold  = 0;
    m_gnt   = N'(1) << w;
    m_ack   = m_gnt;
    m_q     = din_of(w);
  endtask

  task automatic m_reset();
    m_ptr = 0; m_owner = 0; m_hold = 0; m_busy = 0;
    m_gnt = '0; m_ack = '0; m_q = '0;
  endtask

  task automatic m_edge();
    int o;
    if (!m_busy) begin
      if (REQ != 0) m_grant(arb(m_ptr));
      else m_ack = '0;
    end else begin
      o = m_owner;
      if (REQ[o] && LOCK[o] && m_hold < MH - 1) begin
        m_hold++;
        m_q   = din_of(o);
        m_ack = m_gnt;
      end else begin
        m_ptr = (o + 1) % N;
        if (REQ != 0) m_grant(arb(m_ptr));
        else begin
          m_busy = 0; m_gnt = '0; m_ack = '0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".GNT"},   32'(GNT),   32'(m_gnt));
    check({tag, ".ACK"},   32'(ACK),   32'(m_ack));
    check({tag, ".Q"},     32'(Q),     32'(m_q));
    check({tag, ".OWNER"}, 32'(OWNER), 32'(m_owner));
    check({tag, ".BUSY"},  32'(BUSY),  32'(m_busy));
  endtask

  // One clock edge: model follows sampled inputs, outputs read 1 ns later.
  task automatic step(input string tag);
    @(posedge CLK);
    m_edge();
    #1;
    check_all(tag);
  endtask

  // Called 1 ns after an edge; reset pulse lasts 5 ns, clear of edges.
  task automatic pulse_reset(input string tag);
    ARST = 1;
    #2;
    m_reset();
    check_all(tag);
    #3;
    ARST = 0;
  endtask

  initial begin
    #1;
    pulse_reset("rst0");
    check("rst0.Q0", 32'(Q), 0);

    // Single request then idle.
    REQ = 4'b0100; LOCK = '0; DIN = 8'b00_10_01_11;
    step("single");
    check("single.GNT", 32'(GNT), 32'h4);
    check("single.Q", 32'(Q), 32'h2);
    check("single.OWNER", 32'(OWNER), 2);
    REQ = '0;
    step("idle");
    check("idle.GNT", 32'(GNT), 0);
    check("idle.Qhold", 32'(Q), 32'h2);

    // Fairness: order 0,1,2,3,0.
    pulse_reset("rst1");
    REQ = 4'b1111; LOCK = '0; DIN = 8'b11_10_01_00;
    for (int i = 0; i < 5; i++) begin
      step("rr");
      check("rr.order", 32'(GNT), 32'(1 << (i % 4)));
      check("rr.q", 32'(Q), 32'(i % 4));
    end

    // Burst capped at three, then requester 1.
    pulse_reset("rst2");
    REQ = 4'b0011; LOCK = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step("burst");
      check("burst.ack0", 32'(ACK), 32'h1);
    end
    step("forced");
    check("forced.gnt1", 32'(GNT), 32'h2);

    // Sole locked requester regranted with no gap.
    pulse_reset("rst3");
    REQ = 4'b0001; LOCK = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      step("sole");
      check("sole.gnt", 32'(GNT), 32'h1);
      check("sole.ack", 32'(ACK), 32'h1);
    end

    // Owner 3 drops mid-burst; pointer wraps, 1 wins.
    pulse_reset("rst4");
    REQ = 4'b1000; LOCK = 4'b1000; DIN = 8'b01_00_10_11;
    step("own3");
    REQ = 4'b0010;
    step("drop");
    check("drop.gnt", 32'(GNT), 32'h2);
    check("drop.q", 32'(Q), 32'h2);

    // Reset mid-burst with Q=11, owner 2.
    pulse_reset("rst5");
    REQ = 4'b0100; LOCK = 4'b0100; DIN = 8'b00_11_00_00;
    step("pre1");
    step("pre2");
    check("pre.q", 32'(Q), 32'h3);
    pulse_reset("midrst");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      REQ  = N'($urandom);
      LOCK = N'($urandom | $urandom);
      DIN  = (N*W)'($urandom);
      if ($urandom_range(0, 9) < 3) REQ = '0 | N'(1 << $urandom_range(0, N-1));
      step("rand");
      if (n % 97 == 96) pulse_reset("rrst");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
